fifo_uart_tx: RTL and testbench

Drain side of the 16x8 synchronous FIFO. Pops bytes from the FIFO read port whenever data is present and transmits each one on a UART line as 8N1, LSB first. Sits between the FIFO and the board TX pin, so any producer that fills the FIFO gets a serial output stream with no further logic.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/fifo_uart_tx.sv | 100 ++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO and its UART drain logic.
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 16;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // clr realigns the bit period so the first tick lands exactly one bit time later
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as an 8N1 UART frame, LSB first.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = FIFO_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_wr_mon,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              tx,
    output logic              busy
);

    localparam int BCW = $clog2(DATA_W) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [BCW-1:0]    bit_cnt;
    logic              baud_clr;
    logic              baud_tick;

    // Hold the baud counter at zero until the start bit begins
    assign baud_clr = (state == IDLE) || (state == REQ) || (state == LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(baud_tick)
    );

    assign fifo_rd = (state == REQ);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= UART_STOP_BIT;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state <= REQ;
                    end
                end
                // A concurrent FIFO write blocks our read, so keep asking
                REQ: begin
                    if (!fifo_wr_mon) begin
                        state <= fifo_empty ? IDLE : LOAD;
                    end
                end
                LOAD: begin
                    shift <= fifo_dout;
                    tx    <= UART_START_BIT;
                    state <= START;
                end
                START: begin
                    if (baud_tick) begin
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[DATA_W-1:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx      <= UART_STOP_BIT;
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        state <= (enable && !fifo_empty) ? REQ : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO with write priority, frame-level scoreboard of expected waveforms.
module tb_fifo_uart_tx;
    import fifo_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic       wr;
    logic [7:0] wr_data;
    logic       fifo_rd;
    logic [7:0] fifo_dout = 8'h00;
    logic       tx;
    logic       busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [7:0] fifo_q[$];
    int         fifo_count   = 0;
    int         rd_cycles    = 0;
    int         rd_empty_cnt = 0;

    // Each entry is a whole line waveform: bit 0 = start bit, bits 1..8 = data LSB first, bit 9 = stop
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_wr_mon(wr),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .tx         (tx),
        .busy       (busy)
    );

    // FIFO model: write wins over read, read data appears the cycle after an accepted read
    always @(posedge clk) begin
        if (fifo_rd) rd_cycles <= rd_cycles + 1;
        if (fifo_rd && fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
        if (wr) begin
            if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(wr_data);
        end else if (fifo_rd && fifo_q.size() != 0) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_count <= fifo_q.size();
    end

    assign fifo_empty = (fifo_count == 0);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic [9:0] frame);
        wr      = 1'b1;
        wr_data = data;
        exp_q.push_back(frame);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic waitStart(input int gap, output logic [9:0] pat);
        int t = 0;
        while (tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checkOutput("start_seen", tx, 0);
        if (gap >= 0) checkOutput("start_gap", t, gap);
        assert_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("[TB] FAIL frame_expect: actual=frame_started required=nothing_queued");
            pat = 10'h3ff;
        end else begin
            pat = exp_q.pop_front();
        end
    endtask

    task automatic checkFrame(input int gap, input int drop_at);
        logic [9:0] pat;
        waitStart(gap, pat);
        checkOutput("busy_in_frame", busy, 1);
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k == drop_at) enable = 1'b0;
            checkOutput($sformatf("frame_bit%0d", k / CPB), tx, pat[k / CPB]);
            @(negedge clk);
        end
    endtask

    initial begin
        int         rd_base;
        logic [9:0] pat;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h01, 10'b1_00000001_0};
        vecs[2] = '{8'h80, 10'b1_10000000_0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0};
        vecs[4] = '{8'h5A, 10'b1_01011010_0};
        vecs[5] = '{8'hE7, 10'b1_11100111_0};
        vecs[6] = '{8'h3B, 10'b1_00111011_0};
        vecs[7] = '{8'h3C, 10'b1_00111100_0};
        vecs[8] = '{8'hC3, 10'b1_11000011_0};
        vecs[9] = '{8'h96, 10'b1_10010110_0};

        rst = 1'b1; enable = 1'b0; wr = 1'b0; wr_data = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_tx", tx, 1);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_rd", fifo_rd, 0);
        end
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_tx", tx, 1);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_rd", fifo_rd, 0);
        end

        $display("[TB] single byte frame");
        rd_base = rd_cycles;
        applyStimulus(vecs[0].data, vecs[0].frame);
        checkFrame(3, -1);
        checkOutput("single_busy_after", busy, 0);
        checkOutput("single_rd_pulses", rd_cycles - rd_base, 1);

        $display("[TB] three back-to-back frames");
        enable = 1'b0;
        rd_base = rd_cycles;
        for (int i = 1; i <= 3; i++) applyStimulus(vecs[i].data, vecs[i].frame);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) checkFrame((i == 1) ? 3 : 2, -1);
        checkOutput("b2b_rd_pulses", rd_cycles - rd_base, 3);
        checkOutput("b2b_fifo_empty", fifo_empty, 1);
        checkOutput("b2b_busy_after", busy, 0);

        $display("[TB] write collision during read request");
        rd_base = rd_cycles;
        applyStimulus(vecs[4].data, vecs[4].frame);
        @(negedge clk);
        checkOutput("coll_rd_1", fifo_rd, 1);
        wr = 1'b1; wr_data = vecs[5].data; exp_q.push_back(vecs[5].frame);
        @(negedge clk);
        checkOutput("coll_rd_2", fifo_rd, 1);
        wr_data = vecs[6].data; exp_q.push_back(vecs[6].frame);
        @(negedge clk);
        wr = 1'b0;
        checkOutput("coll_rd_3", fifo_rd, 1);
        checkFrame(2, 0);
        checkOutput("coll_rd_cycles", rd_cycles - rd_base, 3);
        checkOutput("coll_fifo_left", fifo_count, 2);
        checkOutput("coll_busy_after", busy, 0);
        enable = 1'b1;
        checkFrame(3, -1);
        checkFrame(2, -1);

        $display("[TB] enable gating");
        enable = 1'b0;
        rd_base = rd_cycles;
        applyStimulus(vecs[7].data, vecs[7].frame);
        repeat (10) @(negedge clk);
        checkOutput("dis_no_rd", rd_cycles - rd_base, 0);
        checkOutput("dis_busy", busy, 0);
        enable = 1'b1;
        checkFrame(3, 13);
        checkOutput("dis_one_rd", rd_cycles - rd_base, 1);
        applyStimulus(8'h77, 10'b1_01110111_0);
        repeat (10) @(negedge clk);
        checkOutput("dis_no_more_rd", rd_cycles - rd_base, 1);
        checkOutput("dis_busy_after", busy, 0);
        enable = 1'b1;
        checkFrame(3, -1);

        $display("[TB] reset mid-frame");
        applyStimulus(vecs[8].data, vecs[8].frame);
        waitStart(3, pat);
        repeat (18) @(negedge clk);
        checkOutput("mid_bit3", tx, pat[4]);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_tx", tx, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rd", fifo_rd, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(vecs[9].data, vecs[9].frame);
        checkFrame(3, -1);

        $display("[TB] randomized traffic");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] b;
                    repeat ($urandom_range(0, 25)) @(negedge clk);
                    b = 8'($urandom_range(0, 255));
                    applyStimulus(b, {UART_STOP_BIT, b, UART_START_BIT});
                end
            end
            begin
                for (int i = 0; i < 8; i++) checkFrame(-1, -1);
            end
        join
        repeat (5) @(negedge clk);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_fifo_empty", fifo_empty, 1);
        checkOutput("end_exp_left", exp_q.size(), 0);
        checkOutput("end_rd_when_empty", rd_empty_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
